cnu_msg_gen: RTL and testbench

- Downstream stage of the check-node min-finder tree. Takes one compressed check-node record per row: min1, min2, the min1 edge index, and per-edge input signs.
- Expands each record serially into deg offset-min-sum check-to-variable messages, one per cycle, in sign-magnitude form, for the VNU side.
- Two-entry record buffer (active plus pending) so the next row's record can be accepted while the current row is still emitting.

---
 rtl/cnu_pkg.sv | 26 ++
 rtl/cnu_offset_sat.sv | 25 ++
 rtl/cnu_msg_gen.sv | 135 +++++++++++++
 tb/tb_cnu_msg_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnu_pkg.sv
// Shared types and widths for the check-node message generator.
// Record layout, buffer states and sign-magnitude message width.
package cnu_pkg;

  localparam int data_w = 9;
  localparam int idx_w  = 3;
  localparam int deg    = 8;
  localparam int msg_w  = data_w + 1;
  // Sign storage is sized for the largest degree idx_w can address.
  localparam int sgn_w  = 1 << idx_w;

  typedef struct packed {
    logic [data_w-1:0] min1;
    logic [data_w-1:0] min2;
    logic [idx_w-1:0]  idx;
    logic [sgn_w-1:0]  signs;
    logic              tsign;
  } rec_t;

  typedef enum logic [1:0] {
    st_empty,
    st_one,
    st_two
  } buf_st_t;

endpackage

// File: rtl/cnu_offset_sat.sv
// Per-edge min select, offset subtract and saturate-at-zero.
// Ports: min1/min2/idx from record, cur edge, sign in; msg = {sign, mag}.
module cnu_offset_sat #(
  parameter int data_w = 9,
  parameter int idx_w  = 3,
  parameter int offset = 1
) (
  input  logic [data_w-1:0] min1,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  idx,
  input  logic [idx_w-1:0]  cur,
  input  logic              sign,
  output logic [data_w:0]   msg
);

  localparam logic [data_w-1:0] off = data_w'(offset);

  logic [data_w-1:0] mag;
  logic [data_w-1:0] mag_o;

  assign mag   = (cur == idx) ? min2 : min1;
  assign mag_o = (mag > off) ? mag - off : '0;
  assign msg   = {sign, mag_o};

endmodule

// File: rtl/cnu_msg_gen.sv
// Expands compressed check-node records into deg c2v messages, one per cycle.
// Ports: clk, rst; in_* record handshake; out_* {sign,mag} message stream.
module cnu_msg_gen #(
  parameter int data_w = cnu_pkg::data_w,
  parameter int idx_w  = cnu_pkg::idx_w,
  parameter int deg    = cnu_pkg::deg,
  parameter int offset = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] in_min1,
  input  logic [data_w-1:0] in_min2,
  input  logic [idx_w-1:0]  in_idx,
  input  logic [deg-1:0]    in_signs,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_msg,
  output logic [idx_w-1:0]  out_edge,
  output logic              out_last
);

  import cnu_pkg::*;

  localparam logic [idx_w-1:0] last_e = idx_w'(deg - 1);

  buf_st_t state;
  buf_st_t nxt;

  rec_t act;
  rec_t pend;
  rec_t new_rec;

  logic [idx_w-1:0] cnt;
  logic [data_w:0]  msg;

  logic act_v;
  logic pend_v;
  logic last;
  logic xfer;
  logic retire;
  logic accept;
  logic load_act;
  logic load_pend;
  logic move;

  assign act_v  = (state != st_empty);
  assign pend_v = (state == st_two);
  assign last   = (cnt == last_e);
  assign xfer   = act_v & out_ready;
  assign retire = xfer & last;
  assign accept = in_valid & ~pend_v;

  always_comb begin
    new_rec       = '0;
    new_rec.min1  = in_min1;
    new_rec.min2  = in_min2;
    new_rec.idx   = in_idx;
    new_rec.signs = sgn_w'(in_signs);
    new_rec.tsign = ^in_signs;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= st_empty;
    else     state <= nxt;
  end

  // A retiring record hands the slot straight to the next one
  // (pending or incoming) so the output stream has no bubble.
  always_comb begin
    nxt       = state;
    load_act  = 1'b0;
    load_pend = 1'b0;
    move      = 1'b0;
    unique case (state)
      st_empty: begin
        if (accept) begin
          load_act = 1'b1;
          nxt      = st_one;
        end
      end
      st_one: begin
        if (retire && accept) begin
          load_act = 1'b1;
        end else if (retire) begin
          nxt = st_empty;
        end else if (accept) begin
          load_pend = 1'b1;
          nxt       = st_two;
        end
      end
      st_two: begin
        if (retire) begin
          move = 1'b1;
          nxt  = st_one;
        end
      end
      default: nxt = st_empty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act  <= '0;
      pend <= '0;
      cnt  <= '0;
    end else begin
      if (load_act)  act  <= new_rec;
      else if (move) act  <= pend;
      if (load_pend) pend <= new_rec;
      if (xfer)      cnt  <= last ? '0 : cnt + 1'b1;
    end
  end

  cnu_offset_sat #(
    .data_w (data_w),
    .idx_w  (idx_w),
    .offset (offset)
  ) u_sat (
    .min1 (act.min1),
    .min2 (act.min2),
    .idx  (act.idx),
    .cur  (cnt),
    .sign (act.tsign ^ act.signs[cnt]),
    .msg  (msg)
  );

  assign in_ready  = ~pend_v;
  assign out_valid = act_v;
  assign out_msg   = act_v ? msg : '0;
  assign out_edge  = cnt;
  assign out_last  = act_v & last;

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Directed bench for cnu_msg_gen: table vectors plus
// back-to-back, backpressure, reset and degree-override sequences.
module tb_cnu_msg_gen;

  typedef struct packed {
    logic [8:0]          min1;
    logic [8:0]          min2;
    logic [2:0]          idx;
    logic [7:0]          signs;
    logic [0:7][9:0]     exp;
  } vec_t;

  logic       clk = 0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_min1;
  logic [8:0] in_min2;
  logic [2:0] in_idx;
  logic [7:0] in_signs;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_msg;
  logic [2:0] out_edge;
  logic       out_last;

  logic       in_valid6;
  logic       in_ready6;
  logic [8:0] in_min16;
  logic [8:0] in_min26;
  logic [2:0] in_idx6;
  logic [5:0] in_signs6;
  logic       out_valid6;
  logic       out_ready6;
  logic [9:0] out_msg6;
  logic [2:0] out_edge6;
  logic       out_last6;

  int n_pass = 0;
  int n_tot  = 0;

  vec_t tbl [5];

  always #5 clk = ~clk;

  cnu_msg_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_min1   (in_min1),
    .in_min2   (in_min2),
    .in_idx    (in_idx),
    .in_signs  (in_signs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_msg   (out_msg),
    .out_edge  (out_edge),
    .out_last  (out_last)
  );

  cnu_msg_gen #(.deg(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .in_min1   (in_min16),
    .in_min2   (in_min26),
    .in_idx    (in_idx6),
    .in_signs  (in_signs6),
    .out_valid (out_valid6),
    .out_ready (out_ready6),
    .out_msg   (out_msg6),
    .out_edge  (out_edge6),
    .out_last  (out_last6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    else
      n_pass++;
  endtask

  task automatic drive(input vec_t v);
    in_min1  = v.min1;
    in_min2  = v.min2;
    in_idx   = v.idx;
    in_signs = v.signs;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    chk({nm, "_pre_v"}, 32'(out_valid), 0);
    chk({nm, "_rdy"}, 32'(in_ready), 1);
    in_valid = 1;
    drive(v);
    tick();
    in_valid = 0;
    for (int e = 0; e < 8; e++) begin
      chk({nm, "_v"}, 32'(out_valid), 1);
      chk({nm, "_msg"}, 32'(out_msg), 32'(v.exp[e]));
      chk({nm, "_edge"}, 32'(out_edge), e);
      chk({nm, "_last"}, 32'(out_last), (e == 7) ? 1 : 0);
      tick();
    end
    chk({nm, "_done"}, 32'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t b2b [3];
    int   k;
    int   n;
    int   first_v;
    int   last_v;
    int   acc2;
    logic acc;
    logic [3:0] bp;

    tbl[0] = '{9'd5, 9'd9, 3'd2, 8'b0000_0101,
               {10'h204, 10'h004, 10'h208, 10'h004,
                10'h004, 10'h004, 10'h004, 10'h004}};
    tbl[1] = '{9'd1, 9'd0, 3'd0, 8'b1000_0000,
               {10'h200, 10'h200, 10'h200, 10'h200,
                10'h200, 10'h200, 10'h200, 10'h000}};
    tbl[2] = '{9'd0, 9'd0, 3'd3, 8'hff,
               {10'h200, 10'h200, 10'h200, 10'h200,
                10'h200, 10'h200, 10'h200, 10'h200}};
    tbl[3] = '{9'd10, 9'd3, 3'd5, 8'b0000_0011,
               {10'h209, 10'h209, 10'h009, 10'h009,
                10'h009, 10'h002, 10'h009, 10'h009}};
    tbl[4] = '{9'd20, 9'd300, 3'd7, 8'b1110_0000,
               {10'h213, 10'h213, 10'h213, 10'h213,
                10'h213, 10'h013, 10'h013, 10'h12b}};

    rst       = 1;
    in_valid  = 0;
    in_min1   = 0;
    in_min2   = 0;
    in_idx    = 0;
    in_signs  = 0;
    out_ready = 1;
    in_valid6 = 0;
    in_min16  = 0;
    in_min26  = 0;
    in_idx6   = 0;
    in_signs6 = 0;
    out_ready6 = 1;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_msg", 32'(out_msg), 0);
    chk("rst_edge", 32'(out_edge), 0);
    chk("rst_last", 32'(out_last), 0);
    rst = 0;
    tick();

    run_vec(tbl[0], "basic");
    run_vec(tbl[1], "sat");
    run_vec(tbl[2], "zero");
    run_vec(tbl[3], "min2lt");
    run_vec(tbl[4], "large");

    // Back-to-back: R2 can only enter once R0 retires and frees
    // the pending slot, i.e. on R1's first-edge cycle (cycle 9).
    b2b[0]  = tbl[0];
    b2b[1]  = tbl[3];
    b2b[2]  = tbl[4];
    k       = 0;
    n       = 0;
    first_v = -1;
    last_v  = -1;
    acc2    = -1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (k < 3);
      if (k < 3) drive(b2b[k]);
      if (c == 2) chk("b2b_rdy_drop", 32'(in_ready), 0);
      if (out_valid) begin
        if (n < 24) begin
          chk("b2b_msg", 32'(out_msg),
              32'(b2b[n / 8].exp[n % 8]));
          chk("b2b_edge", 32'(out_edge), n % 8);
        end
        if (first_v < 0) first_v = c;
        last_v = c;
        n++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        if (k == 2) acc2 = c;
        k++;
      end
    end
    in_valid = 0;
    chk("b2b_count", n, 24);
    chk("b2b_first", first_v, 1);
    chk("b2b_nogap", last_v - first_v, 23);
    chk("b2b_acc3", acc2, 9);

    // Backpressure: out_ready pattern 1,0,0,1 repeating.
    bp = 4'b1001;
    in_valid = 1;
    drive(tbl[0]);
    tick();
    in_valid = 0;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      out_ready = bp[c % 4];
      chk("bp_v", 32'(out_valid), 1);
      chk("bp_msg", 32'(out_msg), 32'(tbl[0].exp[n]));
      chk("bp_edge", 32'(out_edge), n);
      acc = out_ready && out_valid;
      tick();
      if (acc) n++;
    end
    out_ready = 1;
    chk("bp_count", n, 8);
    chk("bp_done", 32'(out_valid), 0);

    // Reset mid-record with B pending.
    in_valid = 1;
    drive(tbl[0]);
    tick();
    drive(tbl[3]);
    tick();
    in_valid = 0;
    chk("mr_pend", 32'(in_ready), 0);
    for (int i = 0; i < 10; i++) begin
      if (out_edge == 3) break;
      tick();
    end
    chk("mr_edge3", 32'(out_edge), 3);
    rst = 1;
    tick();
    rst = 0;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_ready", 32'(in_ready), 1);
    chk("mr_msg", 32'(out_msg), 0);
    chk("mr_edge", 32'(out_edge), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_idle", 32'(out_valid), 0);
    end
    run_vec(tbl[4], "mr_c");

    // Degree override: idx 7 is outside 0..5, so min1 everywhere.
    in_valid6 = 1;
    in_min16  = 9'd12;
    in_min26  = 9'd2;
    in_idx6   = 3'd7;
    in_signs6 = 6'b000001;
    tick();
    in_valid6 = 0;
    for (int e = 0; e < 6; e++) begin
      chk("d6_v", 32'(out_valid6), 1);
      chk("d6_msg", 32'(out_msg6), (e == 0) ? 32'h00b : 32'h20b);
      chk("d6_edge", 32'(out_edge6), e);
      chk("d6_last", 32'(out_last6), (e == 5) ? 1 : 0);
      tick();
    end
    chk("d6_done", 32'(out_valid6), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
